// File: rtl/sigdelay_pkg.sv
// Shared types and default sizing for the audio delay-line sequencer.
package sigdelay_pkg;

    localparam int unsigned SD_A_WIDTH       = 9;
    localparam int unsigned SD_D_WIDTH       = 8;
    localparam int unsigned SD_DEFAULT_DELAY = 64;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        SLEW   = 2'd2,
        FREEZE = 2'd3
    } state_t;

endpackage

// File: rtl/sigdelay_ctrl_cnt.sv
// Write-pointer counter: wraps naturally at 2**W, advances only when enabled.
module sigdelay_ctrl_cnt
    import sigdelay_pkg::*;
#(
    parameter int unsigned W = SD_A_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sigdelay_ctrl.sv
// Delay-line sequencer: owns dpram pointers/enables, delay slewing, freeze looping
// and output muting while the read window is not yet backed by written samples.
module sigdelay_ctrl
    import sigdelay_pkg::*;
#(
    parameter int unsigned A_WIDTH       = SD_A_WIDTH,
    parameter int unsigned D_WIDTH       = SD_D_WIDTH,
    parameter int unsigned DEFAULT_DELAY = SD_DEFAULT_DELAY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [A_WIDTH-1:0] delay_tgt,
    input  logic               delay_ld,
    input  logic               freeze,
    input  logic [D_WIDTH-1:0] ram_rout,
    output logic               ram_wen,
    output logic               ram_ren,
    output logic [A_WIDTH-1:0] ram_waddr,
    output logic [A_WIDTH-1:0] ram_raddr,
    output logic [D_WIDTH-1:0] speaker,
    output logic [A_WIDTH-1:0] cur_delay,
    output state_t             state
);

    localparam logic [A_WIDTH-1:0] FILL_MAX = '1;
    localparam logic [A_WIDTH-1:0] DLY_RST  = A_WIDTH'(DEFAULT_DELAY);

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] cur_q, cur_d;
    logic [A_WIDTH-1:0] tgt_q, tgt_d;
    logic [A_WIDTH-1:0] fill_q, fill_d;
    logic [A_WIDTH-1:0] loop_q, loop_d;
    logic               mute_q, mute_d;
    logic [A_WIDTH-1:0] waddr;
    logic [A_WIDTH-1:0] ld_val;
    logic               wr_tick;

    // A zero delay would read the slot being written; treat it as one sample.
    assign ld_val  = (delay_tgt == '0) ? A_WIDTH'(1) : delay_tgt;
    assign wr_tick = en & (state_q != FREEZE);

    sigdelay_ctrl_cnt #(
        .W (A_WIDTH)
    ) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (wr_tick),
        .cnt_o (waddr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cur_q   <= DLY_RST;
            tgt_q   <= DLY_RST;
            fill_q  <= '0;
            loop_q  <= '0;
            mute_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            fill_q  <= fill_d;
            loop_q  <= loop_d;
            mute_q  <= mute_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        fill_d  = fill_q;
        loop_d  = loop_q;
        mute_d  = mute_q;

        if (wr_tick && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + A_WIDTH'(1);
        end
        // Mute tracks the read issued on this tick, so it lines up with ram_rout next cycle.
        if (en) begin
            mute_d = (state_q == FILL) || (cur_q > fill_q);
        end

        case (state_q)
            FILL: begin
                if (delay_ld) begin
                    cur_d = ld_val;
                    tgt_d = ld_val;
                end else if (fill_d >= cur_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (freeze) begin
                    state_d = FREEZE;
                end else if (delay_ld) begin
                    tgt_d = ld_val;
                    if (ld_val != cur_q) begin
                        state_d = SLEW;
                    end
                end
            end
            SLEW: begin
                if (freeze) begin
                    state_d = FREEZE;
                    tgt_d   = cur_q;
                end else begin
                    if (en) begin
                        if (cur_q < tgt_q) begin
                            cur_d = cur_q + A_WIDTH'(1);
                        end else if (cur_q > tgt_q) begin
                            cur_d = cur_q - A_WIDTH'(1);
                        end
                    end
                    if (delay_ld) begin
                        tgt_d = ld_val;
                    end
                    if (cur_d == tgt_d) begin
                        state_d = RUN;
                    end
                end
            end
            FREEZE: begin
                if (!freeze) begin
                    state_d = RUN;
                    loop_d  = '0;
                end else if (en) begin
                    loop_d = ((loop_q + A_WIDTH'(1)) == cur_q) ? '0 : loop_q + A_WIDTH'(1);
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // loop_q is zero outside FREEZE, so one expression covers every state.
    assign ram_wen   = wr_tick;
    assign ram_ren   = en;
    assign ram_waddr = waddr;
    assign ram_raddr = waddr - cur_q + loop_q;
    assign speaker   = mute_q ? '0 : ram_rout;
    assign cur_delay = cur_q;
    assign state     = state_q;

endmodule

// File: tb/tb_sigdelay_ctrl.sv
// Self-checking bench for sigdelay_ctrl with a behavioural dpram and reference model.
module tb_sigdelay_ctrl;
    import sigdelay_pkg::*;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 8;
    localparam int          DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          delay_ld = 1'b0;
    logic          freeze = 1'b0;
    logic [AW-1:0] delay_tgt = '0;
    logic [DW-1:0] ram_rout = '0;
    logic [DW-1:0] din = '0;
    logic          ram_wen, ram_ren;
    logic [AW-1:0] ram_waddr, ram_raddr, cur_delay;
    logic [DW-1:0] speaker;
    state_t        state;

    logic [DW-1:0] mem [DEPTH];

    // reference model state
    state_t        m_mode;
    int            m_wc, m_cur, m_tgt, m_ft, m_spk;
    bit            m_mute;
    logic [DW-1:0] m_mem [DEPTH];
    bit            fz_lvl;

    int total = 0;
    int bad   = 0;

    sigdelay_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .delay_tgt (delay_tgt),
        .delay_ld  (delay_ld),
        .freeze    (freeze),
        .ram_rout  (ram_rout),
        .ram_wen   (ram_wen),
        .ram_ren   (ram_ren),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .speaker   (speaker),
        .cur_delay (cur_delay),
        .state     (state)
    );

    always #5 clk = ~clk;

    // dpram with one-cycle registered read
    always @(posedge clk) begin
        if (ram_ren) ram_rout <= mem[ram_raddr];
        if (ram_wen) mem[ram_waddr] <= din;
    end

    function automatic int m_waddr();
        return m_wc % DEPTH;
    endfunction

    function automatic int m_fill();
        return (m_wc > DEPTH - 1) ? DEPTH - 1 : m_wc;
    endfunction

    function automatic int m_raddr();
        int r;
        r = m_waddr() - m_cur + ((m_mode == FREEZE) ? (m_ft % m_cur) : 0);
        return (r + 2 * DEPTH) % DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = FILL;
        m_wc   = 0;
        m_cur  = 64;
        m_tgt  = 64;
        m_ft   = 0;
        m_mute = 1'b1;
        m_spk  = 0;
    endtask

    task automatic model_step(input bit e, input bit ld, input int t, input bit fz);
        int ldv;
        int rd;
        ldv = (t == 0) ? 1 : t;
        if (e) begin
            rd     = int'(m_mem[m_raddr()]);
            m_mute = (m_mode == FILL) || (m_cur > m_fill());
            m_spk  = m_mute ? 0 : rd;
        end
        if (e && (m_mode != FREEZE)) begin
            m_mem[m_waddr()] = din;
            m_wc++;
        end
        case (m_mode)
            FILL: begin
                if (ld) begin
                    m_cur = ldv;
                    m_tgt = ldv;
                end else if (m_fill() >= m_cur) begin
                    m_mode = RUN;
                end
            end
            RUN: begin
                if (fz) m_mode = FREEZE;
                else if (ld) begin
                    m_tgt = ldv;
                    if (ldv != m_cur) m_mode = SLEW;
                end
            end
            SLEW: begin
                if (fz) begin
                    m_mode = FREEZE;
                    m_tgt  = m_cur;
                end else begin
                    if (e) m_cur += (m_tgt > m_cur) ? 1 : ((m_tgt < m_cur) ? -1 : 0);
                    if (ld) m_tgt = ldv;
                    if (m_cur == m_tgt) m_mode = RUN;
                end
            end
            default: begin
                if (!fz) begin
                    m_mode = RUN;
                    m_ft   = 0;
                end else if (e) begin
                    m_ft++;
                end
            end
        endcase
    endtask

    // One clock: drive inputs, check combinational outputs, advance, check registered outputs.
    task automatic cyc(input bit e, input bit ld, input int t, input bit fz);
        en        = e;
        delay_ld  = ld;
        delay_tgt = AW'(t);
        freeze    = fz;
        din       = DW'($urandom_range(1, 255));
        #1;
        chk("wen", 32'(ram_wen), 32'(e && (m_mode != FREEZE)));
        chk("ren", 32'(ram_ren), 32'(e));
        chk("waddr", 32'(ram_waddr), m_waddr());
        chk("raddr", 32'(ram_raddr), m_raddr());
        model_step(e, ld, t, fz);
        @(posedge clk);
        #1;
        chk("state", 32'(state), 32'(m_mode));
        chk("cur_delay", 32'(cur_delay), m_cur);
        chk("speaker", 32'(speaker), m_spk);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, fz_lvl);
    endtask

    task automatic do_reset();
        en       = 1'b0;
        delay_ld = 1'b0;
        freeze   = 1'b0;
        fz_lvl   = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_state", 32'(state), 32'(FILL));
        chk("rst_cur", 32'(cur_delay), 64);
        chk("rst_speaker", 32'(speaker), 0);
        chk("rst_waddr", 32'(ram_waddr), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]   = '0;
            m_mem[i] = '0;
        end
        model_reset();
        #1;
        do_reset();

        // fill phase: muted until 64 samples are in
        tick(63);
        chk("fill_state", 32'(state), 32'(FILL));
        chk("fill_speaker", 32'(speaker), 0);
        tick(1);
        chk("run_after_64", 32'(state), 32'(RUN));
        chk("raddr_after_64", 32'(ram_raddr), 0);
        tick(10);

        // slew up to 70, one step per tick
        cyc(1'b0, 1'b1, 70, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk("slew_up", 32'(cur_delay), 64 + k);
        end
        chk("slew_done", 32'(state), 32'(RUN));
        cyc(1'b0, 1'b1, 64, 1'b0);
        tick(6);

        // pointer wrap with delay 64
        n = 0;
        while ((m_waddr() != 0) && (n < 1000)) begin
            tick(1);
            n++;
        end
        chk("wrap_waddr", 32'(ram_waddr), 0);
        chk("wrap_raddr", 32'(ram_raddr), 448);

        // zero target clamps to one
        cyc(1'b0, 1'b1, 0, 1'b0);
        tick(63);
        chk("clamp_cur", 32'(cur_delay), 1);
        chk("clamp_state", 32'(state), 32'(RUN));
        cyc(1'b0, 1'b1, 64, 1'b0);
        tick(63);

        // freeze at waddr 200: loop 136..199
        n = 0;
        while ((m_waddr() != 200) && (n < 1000)) begin
            tick(1);
            n++;
        end
        chk("frz_waddr", 32'(ram_waddr), 200);
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("frz_state", 32'(state), 32'(FREEZE));
        for (int k = 0; k < 150; k++) begin
            chk("frz_loop", 32'(ram_raddr), 136 + (k % 64));
            cyc(1'b1, 1'b0, 0, 1'b1);
        end
        cyc(1'b0, 1'b0, 0, 1'b0);
        chk("unfrz_raddr", 32'(ram_raddr), 136);
        chk("unfrz_waddr", 32'(ram_waddr), 200);
        tick(1);
        chk("unfrz_write", 32'(ram_waddr), 201);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 29) == 0) fz_lvl = ~fz_lvl;
            cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                int'($urandom_range(0, 511)), fz_lvl);
        end

        // reset in the middle of a slew
        fz_lvl = 1'b0;
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, (m_cur > 200) ? 20 : 400, 1'b0);
        tick(3);
        chk("pre_rst_slew", 32'(state), 32'(SLEW));
        do_reset();
        tick(64);
        chk("refill_run", 32'(state), 32'(RUN));

        // freeze wins over a simultaneous load
        cyc(1'b0, 1'b1, 100, 1'b1);
        chk("frz_ld_state", 32'(state), 32'(FREEZE));
        chk("frz_ld_cur", 32'(cur_delay), 64);
        fz_lvl = 1'b1;
        tick(5);
        fz_lvl = 1'b0;
        cyc(1'b0, 1'b0, 0, 1'b0);
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
